// File: rtl/retire_trace_buffer.sv
// ---------------------------------------------------------------------------
// retire_trace_buffer
//
// Watches the commit-side signals of the CPU core and turns every captured
// retire cycle into an 83-bit trace record. Records are queued in a FIFO and
// handed to a host over a valid/ready port. The block also counts captured
// cycles, stops capturing when a cycle-limit watchdog expires, and reports
// completion once the core has halted and the FIFO has drained.
//
// Record layout: {type[2:0], inum[15:0], pc[15:0], a[15:0], b[15:0], c[15:0]}
//   type 0 register write : a = write_reg, b = write_data
//   type 1 load           : a = write_reg, b = write_data, c = mem_addr
//   type 2 store          : a = mem_addr,  b = mem_data
//   type 3 nop / branch
//   type 4 halt
//
// Optional feature macro: TRACE_LOAD_ADDR_EN
//   defined   : loads are emitted as type 1 records carrying the address
//   undefined : loads look like plain register writes, mem_read is unused
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   MAX_CYCLES watchdog limit in captured cycles
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cap_en                       capture enable (core out of reset)
//   pc, reg_write, write_reg,    commit-side view of the retiring
//   write_data, mem_read,        instruction
//   mem_write, mem_addr,
//   mem_data, halt
//   rec_valid, rec_ready,        record output handshake
//   rec_data
//   cycle_cnt, inst_cnt          captured cycles / retired instructions
//   drop_cnt, overflow           dropped records (saturating) / sticky flag
//   done, timeout                halted-and-drained / watchdog expired
// ---------------------------------------------------------------------------
module retire_trace_buffer #(
   parameter int DEPTH      = 16,
   parameter int MAX_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cap_en,
   input  logic [15:0] pc,
   input  logic        reg_write,
   input  logic [3:0]  write_reg,
   input  logic [15:0] write_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        halt,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [82:0] rec_data,
   output logic [31:0] cycle_cnt,
   output logic [15:0] inst_cnt,
   output logic [7:0]  drop_cnt,
   output logic        overflow,
   output logic        done,
   output logic        timeout
);

   localparam int          AW          = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE     = 1;
   localparam logic [AW-1:0] PTR_ONE   = 1;
   localparam logic [31:0] CYCLE_LIMIT = 32'(MAX_CYCLES);

   typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} state_e;

   state_e        state_q, state_d;
   logic [31:0]   cycle_cnt_q, cycle_cnt_d;
   logic [15:0]   inst_cnt_q, inst_cnt_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic          overflow_q, overflow_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [82:0]   mem_q [DEPTH];

   logic          capture;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;
   logic [31:0]   cycle_next;
   logic [2:0]    rec_type;
   logic [15:0]   rec_a;
   logic [15:0]   rec_b;
   logic [15:0]   rec_c;
   logic [82:0]   rec_word;

`ifndef TRACE_LOAD_ADDR_EN
   logic          unused_mem_read;
   assign unused_mem_read = mem_read;
`endif

   // Classify the retiring instruction. A register write outranks halt and
   // store, so an instruction that does both is traced as a register write.
   always_comb begin
      rec_type = 3'd3;
      rec_a    = 16'h0000;
      rec_b    = 16'h0000;
      rec_c    = 16'h0000;
`ifdef TRACE_LOAD_ADDR_EN
      if (reg_write && mem_read) begin
         rec_type = 3'd1;
         rec_a    = {12'h000, write_reg};
         rec_b    = write_data;
         rec_c    = mem_addr;
      end else if (reg_write) begin
`else
      if (reg_write) begin
`endif
         rec_type = 3'd0;
         rec_a    = {12'h000, write_reg};
         rec_b    = write_data;
      end else if (halt) begin
         rec_type = 3'd4;
      end else if (mem_write) begin
         rec_type = 3'd2;
         rec_a    = mem_addr;
         rec_b    = mem_data;
      end
      rec_word = {rec_type, inst_cnt_q, pc, rec_a, rec_b, rec_c};
   end

   // Capture, FIFO bookkeeping and state sequencing. Capture also happens in
   // the IDLE cycle that sees cap_en, so the first retire is never lost. The
   // watchdog looks at the incremented cycle count, which makes the state go
   // TIMEOUT on the same edge that cycle_cnt reaches the limit; a halt on
   // that edge wins. A full FIFO still accepts a push when a pop frees a
   // slot on the same edge.
   always_comb begin
      state_d     = state_q;
      cycle_cnt_d = cycle_cnt_q;
      inst_cnt_d  = inst_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      overflow_d  = overflow_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;

      capture    = cap_en && ((state_q == IDLE) || (state_q == RUN));
      full       = (count_q == FULL_COUNT);
      pop        = rec_valid && rec_ready;
      push       = capture && (!full || pop);
      drop       = capture && full && !pop;
      cycle_next = cycle_cnt_q + 32'd1;

      if (capture) begin
         cycle_cnt_d = cycle_next;
         inst_cnt_d  = inst_cnt_q + 16'd1;
         if (halt) begin
            state_d = HALTED;
         end else if (cycle_next == CYCLE_LIMIT) begin
            state_d = TIMEOUT;
         end else begin
            state_d = RUN;
         end
      end

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
         count_d = count_q - CNT_ONE;
      end
   end

   // State and counter registers; reset discards everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cycle_cnt_q <= 32'd0;
         inst_cnt_q  <= 16'd0;
         drop_cnt_q  <= 8'd0;
         overflow_q  <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         cycle_cnt_q <= cycle_cnt_d;
         inst_cnt_q  <= inst_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
      end
   end

   // Record storage has no reset; stale entries are hidden behind rec_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rec_word;
      end
   end

   // HALTED never pushes again, so once the FIFO empties done holds.
   assign rec_valid = (count_q != '0);
   assign rec_data  = rec_valid ? mem_q[rd_ptr_q] : 83'd0;
   assign cycle_cnt = cycle_cnt_q;
   assign inst_cnt  = inst_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign overflow  = overflow_q;
   assign done      = (state_q == HALTED) && (count_q == '0);
   assign timeout   = (state_q == TIMEOUT);

endmodule

// File: tb/tb_retire_trace_buffer.sv
// ---------------------------------------------------------------------------
// tb_retire_trace_buffer
//
// Directed bench for retire_trace_buffer (DEPTH=8, MAX_CYCLES=20). A table
// of retire vectors with hand-computed records covers classification, then
// hand-written sequences cover FIFO overflow and drain order, cap_en pause,
// halt/done, the watchdog and a halt on the watchdog cycle.
// ---------------------------------------------------------------------------
module tb_retire_trace_buffer;

   localparam int DEPTH      = 8;
   localparam int MAX_CYCLES = 20;

`ifdef TRACE_LOAD_ADDR_EN
   localparam logic [2:0]  LOAD_TYPE = 3'd1;
   localparam logic [15:0] LOAD_C    = 16'h0020;
`else
   localparam logic [2:0]  LOAD_TYPE = 3'd0;
   localparam logic [15:0] LOAD_C    = 16'h0000;
`endif

   typedef struct {
      logic [15:0] pc;
      logic        regWrite;
      logic [3:0]  writeReg;
      logic [15:0] writeData;
      logic        memRead;
      logic        memWrite;
      logic [15:0] memAddr;
      logic [15:0] memData;
      logic        halt;
      logic [2:0]  expType;
      logic [15:0] expA;
      logic [15:0] expB;
      logic [15:0] expC;
   } vector_t;

   logic        clk;
   logic        rst_n;
   logic        cap_en;
   logic [15:0] pc;
   logic        reg_write;
   logic [3:0]  write_reg;
   logic [15:0] write_data;
   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        halt;
   logic        rec_valid;
   logic        rec_ready;
   logic [82:0] rec_data;
   logic [31:0] cycle_cnt;
   logic [15:0] inst_cnt;
   logic [7:0]  drop_cnt;
   logic        overflow;
   logic        done;
   logic        timeout;

   int testsRun    = 0;
   int testsFailed = 0;

   vector_t vecs [7];

   retire_trace_buffer #(
      .DEPTH      (DEPTH),
      .MAX_CYCLES (MAX_CYCLES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cap_en     (cap_en),
      .pc         (pc),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .halt       (halt),
      .rec_valid  (rec_valid),
      .rec_ready  (rec_ready),
      .rec_data   (rec_data),
      .cycle_cnt  (cycle_cnt),
      .inst_cnt   (inst_cnt),
      .drop_cnt   (drop_cnt),
      .overflow   (overflow),
      .done       (done),
      .timeout    (timeout)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one value and log a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [159:0] actual,
                              input logic [159:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drive the commit-side inputs from one vector.
   task automatic applyStimulus(input vector_t v);
      pc         = v.pc;
      reg_write  = v.regWrite;
      write_reg  = v.writeReg;
      write_data = v.writeData;
      mem_read   = v.memRead;
      mem_write  = v.memWrite;
      mem_addr   = v.memAddr;
      mem_data   = v.memData;
      halt       = v.halt;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   function automatic vector_t nopVector(input logic [15:0] pcVal);
      vector_t v;
      v = '{pcVal, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0,
            3'd3, 16'h0, 16'h0, 16'h0};
      return v;
   endfunction

   function automatic vector_t haltVector(input logic [15:0] pcVal);
      vector_t v;
      v = '{pcVal, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1,
            3'd4, 16'h0, 16'h0, 16'h0};
      return v;
   endfunction

   // Register-write event n: write_reg = n[3:0], data 0x100+n, pc 2n.
   function automatic vector_t regEvent(input int n);
      vector_t     v;
      logic [15:0] n16;
      n16 = 16'(n);
      v = '{16'(2 * n), 1'b1, n16[3:0], 16'h0100 + n16, 1'b0, 1'b0, 16'h0,
            16'h0, 1'b0, 3'd0, {12'h000, n16[3:0]}, 16'h0100 + n16, 16'h0};
      return v;
   endfunction

   // Expected record of regEvent(n) captured with inum n.
   function automatic logic [82:0] regRecord(input int n);
      logic [15:0] n16;
      n16 = 16'(n);
      return {3'd0, n16, 16'(2 * n), 12'h000, n16[3:0], 16'h0100 + n16, 16'h0000};
   endfunction

   // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
   task automatic resetDut();
      cap_en    = 1'b0;
      rec_ready = 1'b0;
      applyStimulus(nopVector(16'h0));
      rst_n = 1'b0;
      #1;
      checkOutput("reset_state",
                  160'({rec_valid, rec_data, cycle_cnt, inst_cnt, drop_cnt,
                        overflow, done, timeout}), 160'(0));
      stepCycle();
      rst_n = 1'b1;
      stepCycle();
   endtask

   // Main test sequence.
   initial begin
      rst_n = 1'b1;
      vecs[0] = '{16'h0002, 1'b1, 4'd3, 16'h00AB, 1'b0, 1'b0, 16'h0000, 16'h0000,
                  1'b0, 3'd0, 16'h0003, 16'h00AB, 16'h0000};
      vecs[1] = '{16'h0004, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h1234,
                  1'b0, 3'd2, 16'h0010, 16'h1234, 16'h0000};
      vecs[2] = '{16'h0006, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000,
                  1'b0, 3'd3, 16'h0000, 16'h0000, 16'h0000};
      vecs[3] = '{16'h0008, 1'b1, 4'd5, 16'h7777, 1'b1, 1'b0, 16'h0020, 16'h0000,
                  1'b0, LOAD_TYPE, 16'h0005, 16'h7777, LOAD_C};
      vecs[4] = '{16'h000A, 1'b1, 4'd15, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h0000,
                  1'b0, 3'd0, 16'h000F, 16'hFFFF, 16'h0000};
      vecs[5] = '{16'h000C, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h0000,
                  1'b0, 3'd2, 16'hFFFF, 16'h0000, 16'h0000};
      vecs[6] = '{16'h000E, 1'b1, 4'd1, 16'h0005, 1'b0, 1'b1, 16'h0030, 16'h9999,
                  1'b0, 3'd0, 16'h0001, 16'h0005, 16'h0000};
      #2;

      // Classification table: one record per cycle, drained as it appears.
      resetDut();
      rec_ready = 1'b1;
      cap_en    = 1'b1;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         stepCycle();
         checkOutput($sformatf("vec%0d_record", i), 160'({rec_valid, rec_data}),
                     160'({1'b1, vecs[i].expType, 16'(i), vecs[i].pc, vecs[i].expA,
                           vecs[i].expB, vecs[i].expC}));
         checkOutput($sformatf("vec%0d_counts", i), 160'({inst_cnt, cycle_cnt}),
                     160'({16'(i + 1), 32'(i + 1)}));
      end
      cap_en = 1'b0;
      applyStimulus(nopVector(16'h0));
      stepCycle();
      checkOutput("vec_drained", 160'(rec_valid), 160'(0));

      // Overflow: fill with rec_ready low, then push+pop while full, drain.
      resetDut();
      cap_en = 1'b1;
      for (int k = 0; k < DEPTH + 3; k++) begin
         applyStimulus(regEvent(k));
         stepCycle();
      end
      cap_en = 1'b0;
      applyStimulus(nopVector(16'h0));
      checkOutput("full_drop_state", 160'({drop_cnt, overflow, inst_cnt}),
                  160'({8'd3, 1'b1, 16'(DEPTH + 3)}));
      checkOutput("full_head", 160'({rec_valid, rec_data}), 160'({1'b1, regRecord(0)}));
      stepCycle();
      checkOutput("full_head_stable", 160'({rec_valid, rec_data}),
                  160'({1'b1, regRecord(0)}));
      applyStimulus(regEvent(DEPTH + 3));
      cap_en    = 1'b1;
      rec_ready = 1'b1;
      stepCycle();
      cap_en = 1'b0;
      applyStimulus(nopVector(16'h0));
      checkOutput("full_push_pop", 160'({drop_cnt, inst_cnt}),
                  160'({8'd3, 16'(DEPTH + 4)}));
      for (int k = 0; k < DEPTH; k++) begin
         checkOutput($sformatf("drain%0d", k), 160'({rec_valid, rec_data}),
                     160'({1'b1, regRecord((k < DEPTH - 1) ? k + 1 : DEPTH + 3)}));
         stepCycle();
      end
      checkOutput("drain_empty", 160'(rec_valid), 160'(0));

      // Halt with a cap_en pause in the middle.
      resetDut();
      rec_ready = 1'b1;
      cap_en    = 1'b1;
      applyStimulus(regEvent(0));
      stepCycle();
      checkOutput("halt_seq_rec0", 160'({rec_valid, rec_data}), 160'({1'b1, regRecord(0)}));
      cap_en = 1'b0;
      applyStimulus(regEvent(1));
      stepCycle();
      stepCycle();
      checkOutput("pause_counts", 160'({inst_cnt, cycle_cnt, rec_valid}),
                  160'({16'd1, 32'd1, 1'b0}));
      cap_en = 1'b1;
      for (int k = 1; k < 3; k++) begin
         applyStimulus(regEvent(k));
         stepCycle();
         checkOutput($sformatf("halt_seq_rec%0d", k), 160'({rec_valid, rec_data}),
                     160'({1'b1, regRecord(k)}));
      end
      applyStimulus(haltVector(16'h0040));
      stepCycle();
      checkOutput("halt_record", 160'({rec_valid, rec_data}),
                  160'({1'b1, 3'd4, 16'd3, 16'h0040, 48'd0}));
      checkOutput("halt_not_done_yet", 160'({done, timeout}), 160'(0));
      applyStimulus(regEvent(4));
      stepCycle();
      checkOutput("halt_done", 160'({done, rec_valid}), 160'({1'b1, 1'b0}));
      stepCycle();
      stepCycle();
      checkOutput("halt_no_capture", 160'({inst_cnt, cycle_cnt, done, rec_valid}),
                  160'({16'd4, 32'd4, 1'b1, 1'b0}));

      // Watchdog expiry after MAX_CYCLES captured cycles.
      resetDut();
      rec_ready = 1'b1;
      cap_en    = 1'b1;
      applyStimulus(nopVector(16'h0));
      for (int c = 1; c <= MAX_CYCLES; c++) begin
         stepCycle();
         if (c == MAX_CYCLES - 1) begin
            checkOutput("timeout_before_limit", 160'(timeout), 160'(0));
         end
      end
      checkOutput("timeout_at_limit", 160'({timeout, cycle_cnt, inst_cnt}),
                  160'({1'b1, 32'(MAX_CYCLES), 16'(MAX_CYCLES)}));
      checkOutput("timeout_last_record", 160'({rec_valid, rec_data}),
                  160'({1'b1, 3'd3, 16'(MAX_CYCLES - 1), 64'd0}));
      applyStimulus(regEvent(1));
      stepCycle();
      stepCycle();
      stepCycle();
      checkOutput("timeout_frozen",
                  160'({timeout, cycle_cnt, inst_cnt, rec_valid, done}),
                  160'({1'b1, 32'(MAX_CYCLES), 16'(MAX_CYCLES), 1'b0, 1'b0}));

      // Halt on the watchdog cycle: halt wins.
      resetDut();
      rec_ready = 1'b1;
      cap_en    = 1'b1;
      applyStimulus(nopVector(16'h0));
      for (int c = 1; c < MAX_CYCLES; c++) begin
         stepCycle();
      end
      applyStimulus(haltVector(16'h0028));
      stepCycle();
      checkOutput("limit_halt_record",
                  160'({timeout, cycle_cnt, rec_valid, rec_data}),
                  160'({1'b0, 32'(MAX_CYCLES), 1'b1, 3'd4, 16'(MAX_CYCLES - 1),
                        16'h0028, 48'd0}));
      applyStimulus(nopVector(16'h0));
      stepCycle();
      checkOutput("limit_halt_done", 160'({done, timeout}), 160'({1'b1, 1'b0}));
      stepCycle();
      stepCycle();
      checkOutput("limit_halt_hold", 160'({done, timeout, inst_cnt}),
                  160'({1'b1, 1'b0, 16'(MAX_CYCLES)}));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
